// File: rtl/calc_pkg.sv
// Shared definitions for the calculator engine: operation encoding, FSM states
// and the shift-amount width helper.
package calc_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_MUL = 3'b010;
    localparam logic [2:0] FUNC_DIV = 3'b011;
    localparam logic [2:0] FUNC_AND = 3'b100;
    localparam logic [2:0] FUNC_OR  = 3'b101;
    localparam logic [2:0] FUNC_XOR = 3'b110;
    localparam logic [2:0] FUNC_SHL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Shift amount uses B[clog2(DATA_W):0], i.e. clog2(DATA_W)+1 bits.
    function automatic int shamt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/calc_btn_edge.sv
// Button synchroniser and rising-edge start pulse generator.
// Define CALC_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable clocks before the level changes.
module calc_btn_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic start
);

    logic sync1, sync2, sync3;
    logic level;

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_CNT_W-1:0] stable_cnt;
    logic                db_level;

    // The counter runs only while the synchronised input disagrees with the held level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            db_level   <= 1'b0;
        end else if (sync2 == db_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= '0;
            db_level   <= sync2;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync3 <= 1'b0;
        end else begin
            sync3 <= level;
        end
    end

    assign start = level & ~sync3;

endmodule

// File: rtl/calc_engine.sv
// Parametrised calculator datapath: single-cycle ALU ops plus iterative shift-add
// multiply and restoring divide. Optional button debounce via CALC_DEBOUNCE_EN.
module calc_engine
    import calc_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int RES_W           = 2 * DATA_W,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    output logic [RES_W-1:0]  cal_result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SH_W  = shamt_width(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < 2) begin : g_data_w_check
        $error("DATA_W must be at least 2");
    end
    if (RES_W < 2 * DATA_W) begin : g_res_w_check
        $error("RES_W must be at least 2*DATA_W");
    end

    state_t state_q, state_d;
    logic   start, accept, multi, last;

    logic [2:0]          op_func;
    logic [DATA_W-1:0]   op_a, op_b;
    logic [CNT_W-1:0]    iter;
    logic [2*DATA_W-1:0] acc, mcand, acc_nx;
    logic [DATA_W-1:0]   mplier, rem, quo, rem_nx, quo_nx;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [RES_W-1:0]    a_ext, b_ext, res_nx;

    calc_btn_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .start (start)
    );

    assign busy   = (state_q == EXEC);
    assign accept = (state_q == IDLE) && start;
    assign multi  = (op_func == FUNC_MUL) || (op_func == FUNC_DIV);
    assign last   = !multi || (iter == CNT_W'(DATA_W - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_nx    = acc + (mplier[0] ? mcand : '0);
        div_shift = {rem, quo[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, op_b};
        rem_nx    = div_ge ? DATA_W'(div_shift - {1'b0, op_b}) : div_shift[DATA_W-1:0];
        quo_nx    = {quo[DATA_W-2:0], div_ge};
        a_ext     = RES_W'(op_a);
        b_ext     = RES_W'(op_b);
        res_nx    = '0;
        case (op_func)
            FUNC_ADD: res_nx = a_ext + b_ext;
            FUNC_SUB: res_nx = a_ext - b_ext;
            FUNC_MUL: res_nx = RES_W'(acc_nx);
            FUNC_DIV: res_nx = RES_W'({rem_nx, quo_nx});
            FUNC_AND: res_nx = a_ext & b_ext;
            FUNC_OR:  res_nx = a_ext | b_ext;
            FUNC_XOR: res_nx = a_ext ^ b_ext;
            FUNC_SHL: res_nx = a_ext << op_b[SH_W-1:0];
            default:  res_nx = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXEC;
            EXEC:    if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divide by zero needs no special path: the quotient saturates to all ones
    // and the remainder shifts back to A on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_func    <= FUNC_ADD;
            op_a       <= '0;
            op_b       <= '0;
            iter       <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            cal_result <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_func <= func;
                op_a    <= num1;
                op_b    <= num2;
                err     <= 1'b0;
                iter    <= '0;
                acc     <= '0;
                mcand   <= {DATA_W'(0), num1};
                mplier  <= num2;
                rem     <= '0;
                quo     <= num1;
            end else if (state_q == EXEC) begin
                iter   <= iter + 1'b1;
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                rem    <= rem_nx;
                quo    <= quo_nx;
                if (last) begin
                    cal_result <= res_nx;
                    done       <= 1'b1;
                    if (op_func == FUNC_DIV && op_b == '0) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine (DATA_W=8, RES_W=16): vector table with a
// result scoreboard, plus busy-drop, reset-abort and (with CALC_DEBOUNCE_EN) debounce sequences.
module tb_calc_engine;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
`ifdef CALC_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 3 + DB;

    typedef struct {
        logic [2:0]        func;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RES_W-1:0]  res;
        logic              err;
        int                cycles;
    } vec_t;

    typedef struct {
        logic [RES_W-1:0] res;
        logic             err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              button;
    logic [2:0]        func;
    logic [DATA_W-1:0] num1, num2;
    logic [RES_W-1:0]  cal_result;
    logic              busy, done, err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[16];

    calc_engine #(
        .DATA_W(DATA_W),
        .RES_W(RES_W),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .func      (func),
        .num1      (num1),
        .num2      (num2),
        .cal_result(cal_result),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected done: result 0x%0h with no pending operation", cal_result);
            end else begin
                e = exp_q.pop_front();
                check("result", {16'h0, cal_result}, {16'h0, e.res});
                check("err at done", {31'h0, err}, {31'h0, e.err});
                check("busy low at done", {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic run_op(input vec_t v);
        int lat;
        int cyc;
        int d0;
        d0   = done_cnt;
        func = v.func;
        num1 = v.a;
        num2 = v.b;
        exp_q.push_back('{v.res, v.err});
        button = 1'b1;
        lat = 0;
        while (!busy && lat < LAT + 8) begin
            @(negedge clk);
            lat++;
        end
        check("start latency", lat, LAT);
        check("err cleared on start", {31'h0, err}, 32'h0);
        func = 3'($urandom);
        num1 = 8'($urandom);
        num2 = 8'($urandom);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("exec cycles", cyc, v.cycles);
        button = 1'b0;
        repeat (DB + 6) @(negedge clk);
        check("one done per op", done_cnt - d0, 1);
        check("err held after done", {31'h0, err}, {31'h0, v.err});
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int w;
        vecs[0]  = '{3'b000, 8'hFF, 8'h01, 16'h0100, 1'b0, 1};
        vecs[1]  = '{3'b001, 8'h03, 8'h05, 16'hFFFE, 1'b0, 1};
        vecs[2]  = '{3'b010, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 8};
        vecs[3]  = '{3'b011, 8'd200, 8'd7, 16'h041C, 1'b0, 8};
        vecs[4]  = '{3'b011, 8'h2A, 8'h00, 16'h2AFF, 1'b1, 8};
        vecs[5]  = '{3'b000, 8'h10, 8'h20, 16'h0030, 1'b0, 1};
        vecs[6]  = '{3'b100, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1};
        vecs[7]  = '{3'b101, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1};
        vecs[8]  = '{3'b110, 8'hAA, 8'hFF, 16'h0055, 1'b0, 1};
        vecs[9]  = '{3'b111, 8'h01, 8'h0F, 16'h8000, 1'b0, 1};
        vecs[10] = '{3'b111, 8'hFF, 8'h14, 16'h0FF0, 1'b0, 1};
        vecs[11] = '{3'b010, 8'h00, 8'hAB, 16'h0000, 1'b0, 8};
        vecs[12] = '{3'b011, 8'hFF, 8'hFF, 16'h0001, 1'b0, 8};
        vecs[13] = '{3'b011, 8'h05, 8'h09, 16'h0500, 1'b0, 8};
        vecs[14] = '{3'b001, 8'h00, 8'hFF, 16'hFF01, 1'b0, 1};
        vecs[15] = '{3'b010, 8'h0D, 8'hB7, 16'h094B, 1'b0, 8};

        rst    = 1'b1;
        button = 1'b0;
        func   = 3'b000;
        num1   = '0;
        num2   = '0;
        repeat (3) @(negedge clk);
        check("reset cal_result", {16'h0, cal_result}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle after reset", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i]);
        end

`ifndef CALC_DEBOUNCE_EN
        // Second press while a multiply runs must be dropped.
        d0   = done_cnt;
        func = 3'b010;
        num1 = 8'h12;
        num2 = 8'h34;
        exp_q.push_back('{16'h03A8, 1'b0});
        button = 1'b1;
        w = 0;
        while (!busy && w < LAT + 8) begin
            @(negedge clk);
            w++;
        end
        button = 1'b0;
        repeat (2) @(negedge clk);
        button = 1'b1;
        repeat (3) @(negedge clk);
        check("still busy at second press", {31'h0, busy}, 32'h1);
        button = 1'b0;
        repeat (20) @(negedge clk);
        check("busy press dropped", done_cnt - d0, 1);
        check("idle after dropped press", {31'h0, busy}, 32'h0);
`endif

        // Reset during EXEC cycle 4 aborts without a done pulse.
        d0   = done_cnt;
        func = 3'b010;
        num1 = 8'h77;
        num2 = 8'h99;
        button = 1'b1;
        w = 0;
        while (!busy && w < LAT + 8) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check("busy before abort", {31'h0, busy}, 32'h1);
        check("result held before abort", {16'h0, cal_result}, 32'h03A8 & {32{DB == 0}} | 32'h094B & {32{DB != 0}});
        rst    = 1'b1;
        button = 1'b0;
        #1;
        check("abort cal_result", {16'h0, cal_result}, 32'h0);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        check("abort err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (DB + 15) @(negedge clk);
        check("no done after abort", done_cnt - d0, 0);

`ifdef CALC_DEBOUNCE_EN
        d0 = done_cnt;
        button = 1'b1;
        repeat (10) @(negedge clk);
        button = 1'b0;
        repeat (40) @(negedge clk);
        check("short pulse ignored", done_cnt - d0, 0);
        func = 3'b000;
        num1 = 8'h05;
        num2 = 8'h06;
        exp_q.push_back('{16'h000B, 1'b0});
        button = 1'b1;
        repeat (20) @(negedge clk);
        button = 1'b0;
        repeat (40) @(negedge clk);
        check("long pulse single start", done_cnt - d0, 1);
`endif

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
